// File: rtl/stream_mux_pkg.sv
// Shared constants and FSM state encoding for the N-to-1 packet-locking stream mux.
package stream_mux_pkg;

    localparam int DefaultW = 16;
    localparam int DefaultN = 4;

    typedef logic [0:0] state_t;

    localparam state_t StIdle   = 1'b0;
    localparam state_t StLocked = 1'b1;

endpackage

// File: rtl/stream_mux_arb.sv
// Combinational arbiter: rotating-priority search from ptr_i, or only the locked channel
// while a packet is in flight. A constant zero pointer yields fixed lowest-index priority.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int N = DefaultN
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 lock_i,
    input  logic [$clog2(N)-1:0] lock_idx_i,
    output logic [N-1:0]         gnt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        if (lock_i) begin
            gnt_o[lock_idx_i] = req_i[lock_idx_i];
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr_i) + k) % N;
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 stream mux with a single output register and per-packet channel lock.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int W = DefaultW,
    parameter int N = DefaultN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_sel,
    output logic                 busy
);

    localparam int SW = $clog2(N);

    state_t          state_q, state_d;
    logic [SW-1:0]   lock_idx_q, lock_idx_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [SW-1:0]   out_sel_q, out_sel_d;

    logic [SW-1:0]   ptr;
    logic [N-1:0]    gnt;
    logic            stage_free;
    logic            accept;
    logic [SW-1:0]   acc_idx;
    logic [W-1:0]    acc_data;
    logic            acc_last;

    stream_mux_arb #(
        .N (N)
    ) u_arb (
        .req_i      (in_valid),
        .ptr_i      (ptr),
        .lock_i     (state_q == StLocked),
        .lock_idx_i (lock_idx_q),
        .gnt_o      (gnt)
    );

    // The grant is always a subset of in_valid, so any ready bit means a handshake.
    assign stage_free = !out_valid_q | out_ready;
    assign in_ready   = (stage_free & en) ? gnt : '0;
    assign accept     = |in_ready;

    always_comb begin
        acc_idx  = '0;
        acc_data = '0;
        acc_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                acc_idx  = SW'(i);
                acc_data = in_data[i*W +: W];
                acc_last = in_last[i];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_data;
            out_last_d  = acc_last;
            out_sel_d   = acc_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (state_q == StIdle && !acc_last) begin
                state_d    = StLocked;
                lock_idx_d = acc_idx;
            end else if (state_q == StLocked && acc_last) begin
                state_d = StIdle;
            end
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic [SW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept && acc_last) begin
            ptr_d = (acc_idx == SW'(N - 1)) ? '0 : acc_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lock_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q == StLocked);

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Self-checking bench for stream_mux_nto1: directed scenarios plus randomized traffic
// against a packet-level reference model of the arbitration and output register.
module tb_stream_mux_nto1;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = $clog2(N);

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_last;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic [SW-1:0]     out_sel;
    logic              busy;

    stream_mux_nto1 #(
        .W (W),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef STREAM_MUX_RR_EN
    bit rr_mode = 1'b1;
`else
    bit rr_mode = 1'b0;
`endif

    // Reference model: packet lock, rotation pointer, and what the output register holds.
    bit          m_locked;
    int          m_lock;
    int          m_ptr;
    bit          m_ov;
    logic [W-1:0] m_od;
    bit          m_ol;
    int          m_os;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        if (m_locked) return v[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] put(input logic [N*W-1:0] d, input int ch,
                                           input logic [W-1:0] val);
        logic [N*W-1:0] r;
        r = d;
        r[ch*W +: W] = val;
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_lock   = 0;
        m_ptr    = 0;
        m_ov     = 0;
        m_od     = '0;
        m_ol     = 0;
        m_os     = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("out_data", 32'(out_data), 32'(m_od));
            check("out_last", 32'(out_last), 32'(m_ol));
            check("out_sel", 32'(out_sel), 32'(m_os));
        end
        check("busy", 32'(busy), 32'(m_locked));
    endtask

    // Drive one cycle of inputs, check in_ready, advance the model, check registered outputs.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [N-1:0] l,
                        input logic ordy, input logic e);
        int         g;
        bit         acc;
        logic [N-1:0] er;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        en        = e;
        #1;
        g   = pick(v);
        acc = e && (!m_ov || ordy) && (g >= 0);
        er  = '0;
        if (acc) er[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(er));
        if (acc) begin
            m_ov = 1;
            m_od = d[g*W +: W];
            m_ol = l[g];
            m_os = g;
            if (!m_locked && !l[g]) begin
                m_locked = 1;
                m_lock   = g;
            end else if (m_locked && l[g]) begin
                m_locked = 0;
            end
            if (rr_mode && l[g]) m_ptr = (g + 1) % N;
        end else if (ordy) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Assert reset between clock edges and confirm the clear happens without a clock.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_sel"}, 32'(out_sel), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic           ordy;
        logic           e;
        logic [W-1:0]   held;

        rst_n     = 1'b1;
        en        = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        model_reset();
        #2;
        async_reset("reset0");

        // Single beat from channel 2.
        step(4'b0100, put('0, 2, 16'hBEEF), 4'b0100, 1'b1, 1'b1);
        check("single_data", 32'(out_data), 32'h0000_BEEF);
        check("single_sel", 32'(out_sel), 32'd2);
        check("single_busy", 32'(busy), 32'd0);

        // Channel 1 holds the lock for a 3-beat packet while channel 0 keeps requesting.
        async_reset("reset1");
        step(4'b0010, put('0, 1, 16'h1111), 4'b0000, 1'b1, 1'b1);
        check("lock_b1_busy", 32'(busy), 32'd1);
        step(4'b0011, put(put('0, 0, 16'h0A0A), 1, 16'h2222), 4'b0001, 1'b1, 1'b1);
        check("lock_b2_sel", 32'(out_sel), 32'd1);
        step(4'b0011, put(put('0, 0, 16'h0A0A), 1, 16'h3333), 4'b0011, 1'b1, 1'b1);
        check("lock_b3_sel", 32'(out_sel), 32'd1);
        check("lock_b3_busy", 32'(busy), 32'd0);
        step(4'b0001, put('0, 0, 16'h0A0A), 4'b0001, 1'b1, 1'b1);
        check("lock_after_sel", 32'(out_sel), 32'd0);

        // All channels send back-to-back single-beat packets.
        async_reset("reset2");
        for (int k = 0; k < 5; k++) begin
            d = {16'h3000 + 16'(k), 16'h2000 + 16'(k), 16'h1000 + 16'(k), 16'h0000 + 16'(k)};
            step(4'b1111, d, 4'b1111, 1'b1, 1'b1);
            check("arb_seq_sel", 32'(out_sel), rr_mode ? 32'(k % N) : 32'd0);
        end

        // Backpressure with channel 3 requesting.
        async_reset("reset3");
        step(4'b1000, put('0, 3, 16'hC0DE), 4'b1000, 1'b0, 1'b1);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            step(4'b1000, put('0, 3, 16'(16'hD000 + k)), 4'b1000, 1'b0, 1'b1);
            check("bp_hold", 32'(out_data), 32'h0000_C0DE);
        end
        check("bp_first", 32'(held), 32'h0000_C0DE);
        for (int k = 0; k < 3; k++) begin
            step(4'b1000, put('0, 3, 16'(16'hE000 + k)), 4'b1000, 1'b1, 1'b1);
            check("bp_resume", 32'(out_data), 32'(16'hE000 + k));
        end

        // Enable dropped mid-packet, then reset mid-cycle.
        async_reset("reset4");
        step(4'b0010, put('0, 1, 16'h5555), 4'b0000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, put(put('0, 0, 16'h6666), 1, 16'h7777), 4'b0000, 1'b1, 1'b0);
            check("en_low_busy", 32'(busy), 32'd1);
            check("en_low_valid", 32'(out_valid), 32'd0);
        end
        async_reset("reset5");

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 9) < 6);
                l[i] = ($urandom_range(0, 9) < 4);
            end
            d    = {$urandom, $urandom};
            ordy = ($urandom_range(0, 9) < 7);
            e    = ($urandom_range(0, 19) < 17);
            step(v, d, l, ordy, e);
            if (c % 500 == 321) async_reset("rand_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/stream_mux_nto1.md
STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 Parameter W, default 16, data width per channel in bits (W >= 1).
REQ-002 Parameter N, default 4, number of input channels (N >= 2); SW = $clog2(N).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port en  input  1  global enable; gates acceptance of new input beats.
REQ-006 Port in_valid  input  N  per-channel beat valid.
REQ-007 Port in_ready  output  N  per-channel beat accepted when in_valid[i] & in_ready[i].
REQ-008 Port in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-009 Port in_last  input  N  per-channel end-of-packet marker.
REQ-010 Port out_valid  output  1  output register holds a beat.
REQ-011 Port out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-012 Port out_data  output  W  registered selected data.
REQ-013 Port out_last  output  1  registered end-of-packet marker.
REQ-014 Port out_sel  output  SW  index of the channel that sourced the current output beat.
REQ-015 Port busy  output  1  high while a packet lock is held (state LOCKED).

Function
REQ-016 The output stage SHALL be one register; latency from input acceptance to out_valid is exactly 1 cycle.
REQ-017 The stage SHALL be free when !out_valid | out_ready; input acceptance is allowed only when the stage is free and en=1.
REQ-018 At most one in_ready bit SHALL be high in any cycle, and only for the granted channel.
REQ-019 The FSM SHALL have states IDLE and LOCKED.
REQ-020 In IDLE, the arbiter SHALL grant one channel among those with in_valid=1. If no channel is valid, no channel is granted.
REQ-021 In IDLE, accepting a beat with in_last=0 SHALL move the FSM to LOCKED on the granted channel. Accepting a beat with in_last=1 keeps the FSM in IDLE.
REQ-022 In LOCKED, only the locked channel SHALL be eligible for a grant. Accepting its beat with in_last=1 returns the FSM to IDLE.
REQ-023 An output transfer and a new acceptance in the same cycle SHALL both occur, giving full throughput of 1 beat/cycle.
REQ-024 With out_valid=1 and out_ready=0, out_data, out_last and out_sel SHALL hold stable.
REQ-025 With en=0, no beat SHALL be accepted; the FSM and lock are retained; the output register still drains on out_ready.
REQ-026 A locked channel that deasserts in_valid mid-packet SHALL stall the block; no other channel is granted.

Reset
REQ-027 Asserting rst_n=0 SHALL clear, asynchronously, the following:
- out_valid, out_data, out_last, out_sel and busy to 0.
- The FSM to IDLE.
- The round-robin pointer to 0.
REQ-028 A reset during a packet SHALL discard the lock and any buffered beat; no partial state survives.

Configuration
REQ-029 Macro STREAM_MUX_RR_EN defined: the arbitration policy SHALL be round-robin.
- Search starts at the pointer.
- The pointer moves to (granted+1) mod N when a last beat is accepted.
REQ-030 Macro STREAM_MUX_RR_EN undefined: the arbitration policy SHALL be fixed priority (lowest index wins), and no pointer register exists.
REQ-031 The port list SHALL be identical in both configurations.

Structure
REQ-032 Package stream_mux_pkg SHALL hold the FSM state type (IDLE, LOCKED) and the W/N default constants.
REQ-033 Arbitration SHALL live in sub-module stream_mux_arb, a combinational grant from (request vector, pointer, lock) to a one-hot grant.

Verification
REQ-034 Single beat, reset release, N=4, W=16:
- Stimulus: ch2 valid, data 0xBEEF, last=1; out_ready=1.
- Response: the next cycle shows out_valid=1, out_data=0xBEEF, out_sel=2, busy=0.
REQ-035 Lock holds across a packet:
- Stimulus: ch1 sends 3 beats (last on the 3rd); ch0 is valid throughout.
- Response: out_sel=1 for 3 beats, then ch0 is granted; busy=1 for the first 2 accept cycles only.
REQ-036 Round-robin, RR_EN defined:
- Stimulus: all 4 channels send continuous single-beat packets.
- Response: out_sel sequence is 0,1,2,3,0.
- With the macro undefined, out_sel is 0 repeatedly.
REQ-037 Backpressure:
- Stimulus: out_ready=0 for 5 cycles with ch3 valid.
- Response: out_data is stable and in_ready=0 after the first accept; out_ready=1 then resumes 1 beat/cycle.
REQ-038 Enable and reset:
- Stimulus: en=0 mid-packet.
- Response: no accept, busy stays 1.
- Stimulus: then rst_n=0.
- Response: out_valid=0 and busy=0 immediately, without waiting for clk.
